// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller around decode: load-use stall, branch squash,
// multi-cycle EX hold, operand forwarding selects and stall/flush counters.
//
// state | meaning
// RUN   | normal issue, load-use hazards checked
// FLUSH | squashing wrong-path fetches, countdown running
// BUSY  | multi-cycle EX op holding the front end
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_busy_i,
  input  logic [4:0]       ex_rs1_addr_i,
  input  logic [4:0]       ex_rs2_addr_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic             mem_reg_write_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             wb_reg_write_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_bubble_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [15:0]      flush_count_o
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       flush_evt;
  logic       load_use;
  logic       flush_active;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we, input logic [4:0] wb_rd);
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs)
      return 2'b01;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    load_use = id_valid_i && ex_mem_read_i && ex_reg_write_i && (ex_rd_addr_i != 5'd0) &&
               ((id_uses_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
                (id_uses_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
    // A frozen countdown resumes in the very cycle busy drops
    flush_active = (state == ST_FLUSH) || (state == ST_BUSY && flush_cnt != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    flush_evt     = 1'b0;
    if (ex_busy_i) begin
      state_nxt = ST_BUSY;
    end else if (ex_branch_taken_i) begin
      flush_cnt_nxt = FLUSH_LOAD;
      state_nxt     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      flush_evt     = 1'b1;
    end else if (flush_active) begin
      flush_cnt_nxt = flush_cnt - 4'd1;
      state_nxt     = (flush_cnt != 4'd1) ? ST_FLUSH : ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    fwd_a_sel_o    = 2'b00;
    fwd_b_sel_o    = 2'b00;
    if (rst_n) begin
      fwd_a_sel_o = fwd_sel(ex_rs1_addr_i, mem_reg_write_i, mem_rd_addr_i,
                            wb_reg_write_i, wb_rd_addr_i);
      fwd_b_sel_o = fwd_sel(ex_rs2_addr_i, mem_reg_write_i, mem_rd_addr_i,
                            wb_reg_write_i, wb_rd_addr_i);
      if (ex_busy_i) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_stall_o = 1'b1;
      end else if (ex_branch_taken_i || flush_active) begin
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (load_use) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end
    end
  end

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o <= '0;
      flush_count_o  <= 16'd0;
    end else begin
      if (pc_stall_o)
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (flush_evt && flush_count_o != 16'hFFFF)
        flush_count_o <= flush_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i, id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        ex_mem_read_i, ex_reg_write_i, ex_branch_taken_i, ex_busy_i;
  logic [4:0]  ex_rs1_addr_i, ex_rs2_addr_i, mem_rd_addr_i, wb_rd_addr_i;
  logic        mem_reg_write_i, wb_reg_write_i;
  logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o, state_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_mem_read_i(ex_mem_read_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_branch_taken_i(ex_branch_taken_i), .ex_busy_i(ex_busy_i),
    .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_reg_write_i(mem_reg_write_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_reg_write_i(wb_reg_write_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_stall_o(id_ex_stall_o), .id_ex_bubble_o(id_ex_bubble_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .state_o(state_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_rd_addr_i = 0;
    ex_mem_read_i = 0; ex_reg_write_i = 0; ex_branch_taken_i = 0; ex_busy_i = 0;
    ex_rs1_addr_i = 0; ex_rs2_addr_i = 0; mem_rd_addr_i = 0; wb_rd_addr_i = 0;
    mem_reg_write_i = 0; wb_reg_write_i = 0;
  endtask

  // EX: lw x5 ; ID: add x6,x5,x1
  task automatic set_load_use();
    ex_rd_addr_i = 5'd5; ex_mem_read_i = 1; ex_reg_write_i = 1;
    id_valid_i = 1; id_rs1_addr_i = 5'd5; id_rs2_addr_i = 5'd1; id_uses_rs1_i = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble}
  function automatic logic [31:0] ctl();
    return {27'd0, pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o};
  endfunction

  initial begin
    clear_inputs();
    rst_n = 0;
    set_load_use();
    #2;
    check("rst_ctl", ctl(), 32'h00);
    check("rst_state", state_o, 0);
    check("rst_stall_cnt", stall_cycles_o, 0);
    check("rst_flush_cnt", flush_count_o, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();

    // load-use: one cycle stall+bubble
    set_load_use();
    #1 check("lu_ctl", ctl(), 32'b11001);
    tick();
    ex_mem_read_i = 0;
    #1 check("lu_done_ctl", ctl(), 32'h00);
    check("lu_stall_cnt", stall_cycles_o, 1);

    set_load_use(); ex_rd_addr_i = 0; id_rs1_addr_i = 0;
    #1 check("lu_x0_ctl", ctl(), 32'h00);
    set_load_use(); id_uses_rs1_i = 0;
    #1 check("lu_nouse_ctl", ctl(), 32'h00);
    set_load_use(); id_uses_rs1_i = 0; id_uses_rs2_i = 1; id_rs2_addr_i = 5'd5;
    #1 check("lu_rs2_ctl", ctl(), 32'b11001);
    tick();
    clear_inputs();
    #1 check("lu_rs2_stall_cnt", stall_cycles_o, 2);

    // branch with load_use held throughout: three flush cycles, no stall
    set_load_use(); ex_branch_taken_i = 1;
    #1 check("br0_ctl", ctl(), 32'b00101);
    check("br0_state", state_o, 0);
    tick();
    ex_branch_taken_i = 0;
    #1 check("br1_ctl", ctl(), 32'b00101);
    check("br1_state", state_o, 1);
    tick();
    #1 check("br2_ctl", ctl(), 32'b00101);
    check("br2_state", state_o, 1);
    tick();
    clear_inputs();
    #1 check("br3_ctl", ctl(), 32'h00);
    check("br3_state", state_o, 0);
    check("br_flush_cnt", flush_count_o, 1);
    check("br_stall_cnt", stall_cycles_o, 2);

    // busy arrives on the third flush cycle and lasts four cycles
    ex_branch_taken_i = 1;
    tick();
    ex_branch_taken_i = 0;
    #1 check("bf1_ctl", ctl(), 32'b00101);
    tick();
    ex_busy_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("bf_busy%0d_ctl", i), ctl(), 32'b11010);
      check($sformatf("bf_busy%0d_state", i), state_o, (i == 0) ? 1 : 2);
      tick();
    end
    ex_busy_i = 0;
    #1 check("bf_resume_ctl", ctl(), 32'b00101);
    check("bf_resume_state", state_o, 2);
    tick();
    #1 check("bf_end_ctl", ctl(), 32'h00);
    check("bf_end_state", state_o, 0);
    check("bf_stall_cnt", stall_cycles_o, 6);
    check("bf_flush_cnt", flush_count_o, 2);

    // branch beats load_use in the same cycle
    set_load_use(); ex_branch_taken_i = 1;
    #1 check("br_lu_ctl", ctl(), 32'b00101);
    tick();
    clear_inputs();
    tick();
    tick();
    #1 check("br_lu_state", state_o, 0);
    check("br_lu_flush_cnt", flush_count_o, 3);

    // busy beats branch in the same cycle
    ex_busy_i = 1; ex_branch_taken_i = 1;
    #1 check("busy_br_ctl", ctl(), 32'b11010);
    tick();
    clear_inputs();
    #1 check("busy_br_exit_ctl", ctl(), 32'h00);
    check("busy_br_state", state_o, 2);
    check("busy_br_flush_cnt", flush_count_o, 3);
    tick();
    #1 check("busy_br_run", state_o, 0);
    check("busy_br_stall_cnt", stall_cycles_o, 7);

    // forwarding
    ex_rs1_addr_i = 5'd7; ex_rs2_addr_i = 5'd3;
    mem_rd_addr_i = 5'd7; mem_reg_write_i = 1;
    wb_rd_addr_i = 5'd7; wb_reg_write_i = 1;
    #1 check("fwd_a_mem", fwd_a_sel_o, 2'b01);
    check("fwd_b_none", fwd_b_sel_o, 2'b00);
    mem_reg_write_i = 0;
    #1 check("fwd_a_wb", fwd_a_sel_o, 2'b10);
    wb_rd_addr_i = 5'd3;
    #1 check("fwd_b_wb", fwd_b_sel_o, 2'b10);
    ex_rs1_addr_i = 0; ex_rs2_addr_i = 0; mem_rd_addr_i = 0; wb_rd_addr_i = 0;
    mem_reg_write_i = 1;
    #1 check("fwd_a_x0", fwd_a_sel_o, 2'b00);
    check("fwd_b_x0", fwd_b_sel_o, 2'b00);
    clear_inputs();

    // asynchronous reset in the middle of a flush
    ex_branch_taken_i = 1;
    tick();
    clear_inputs();
    ex_rs1_addr_i = 5'd7; mem_rd_addr_i = 5'd7; mem_reg_write_i = 1;
    #1 check("pre_rst_state", state_o, 1);
    rst_n = 0;
    #1 check("async_rst_ctl", ctl(), 32'h00);
    check("async_rst_state", state_o, 0);
    check("async_rst_fwd", fwd_a_sel_o, 2'b00);
    check("async_rst_stall_cnt", stall_cycles_o, 0);
    check("async_rst_flush_cnt", flush_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the IF/ID/EX pipeline around the decode stage. It does three jobs:
- Detects load-use hazards against the instruction in EX and stalls fetch/decode.
- Squashes wrong-path instructions after a taken branch/jump for a programmable number of cycles.
- Holds the front end while a multi-cycle EX operation is busy.
It also generates the EX operand forwarding selects and stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles if_id_flush_o stays asserted after a taken branch (1..15).
CNT_W, 32, width of stall_cycles_o (wraps modulo 2^CNT_W).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid_i  input  1  ID holds a real instruction
id_rs1_addr_i  input  5  ID source register 1
id_rs2_addr_i  input  5  ID source register 2
id_uses_rs1_i  input  1  ID instruction reads rs1 (0 for LUI/AUIPC/JAL)
id_uses_rs2_i  input  1  ID instruction reads rs2 (R/S/B types only)
ex_rd_addr_i  input  5  EX destination register
ex_mem_read_i  input  1  EX instruction is a load
ex_reg_write_i  input  1  EX instruction writes rd
ex_branch_taken_i  input  1  EX resolved a taken branch/jump (single-cycle pulse)
ex_busy_i  input  1  multi-cycle EX operation not finished
ex_rs1_addr_i  input  5  EX source 1 (forwarding)
ex_rs2_addr_i  input  5  EX source 2 (forwarding)
mem_rd_addr_i  input  5  MEM destination
mem_reg_write_i  input  1  MEM writes rd
wb_rd_addr_i  input  5  WB destination
wb_reg_write_i  input  1  WB writes rd
pc_stall_o  output  1  hold PC
if_id_stall_o  output  1  hold IF/ID register
if_id_flush_o  output  1  clear IF/ID to NOP
id_ex_stall_o  output  1  hold ID/EX register
id_ex_bubble_o  output  1  load NOP into ID/EX
fwd_a_sel_o  output  2  operand A source: 00 RF, 01 MEM, 10 WB
fwd_b_sel_o  output  2  operand B source, same encoding
state_o  output  2  FSM state: 00 RUN, 01 FLUSH, 10 BUSY
stall_cycles_o  output  CNT_W  cycles with pc_stall_o high
flush_count_o  output  16  taken-branch flush events, saturates at 0xFFFF

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, flush counter=0, stall_cycles_o=0, flush_count_o=0.
  - All stall/flush/bubble outputs 0; fwd selects 00.
- Cause signals (combinational):
  - load_use = id_valid_i & ex_mem_read_i & ex_reg_write_i & ex_rd_addr_i!=0 & ((id_uses_rs1_i & rs1==ex_rd) | (id_uses_rs2_i & rs2==ex_rd)).
- Priority, highest first: ex_busy_i > ex_branch_taken_i > FLUSH countdown > load_use.
- Busy:
  - pc_stall_o, if_id_stall_o, id_ex_stall_o = 1; bubble 0; flush 0.
  - Next state BUSY; a pending FLUSH count freezes and resumes after busy drops.
- Taken branch (not busy):
  - if_id_flush_o=1, id_ex_bubble_o=1, stalls 0.
  - Flush counter loads FLUSH_CYCLES-1.
  - Next state FLUSH if FLUSH_CYCLES>1, else RUN.
  - flush_count_o increments (saturating).
  - A branch arriving during FLUSH reloads the counter and counts again.
- FLUSH state (no new branch, not busy):
  - if_id_flush_o=1, id_ex_bubble_o=1.
  - Counter decrements; at 0 next state RUN.
  - load_use is ignored (ID holds wrong-path).
- Load-use (RUN, no higher cause):
  - pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1 in the same cycle.
  - Exactly one cycle, since the load then leaves EX.
- BUSY exit: when ex_busy_i=0, next state is FLUSH if the counter is nonzero, else RUN. The busy-exit cycle itself is evaluated with normal priority.
- Forwarding (purely combinational, independent of state):
  - Select MEM if mem_reg_write_i & mem_rd!=0 & mem_rd==ex_rsX.
  - Else WB if wb_reg_write_i & wb_rd!=0 & wb_rd==ex_rsX.
  - Else 00. x0 is never forwarded.
- Counters:
  - stall_cycles_o increments on every clock edge where pc_stall_o=1 and wraps.
  - Counters are sampled on the rising edge.
- Output rules:
  - All outputs are 0/RF-select while rst_n=0.
  - Stall/flush outputs are combinational from registered state plus current inputs, so the response is zero-latency.

Test Plan:
- Load-use: EX `lw x5`, ID `add x6,x5,x1` (uses_rs1) -> one cycle pc_stall=if_id_stall=bubble=1, then all 0; stall_cycles_o=1. Same case with rd=x0 or uses_rs1=0 -> no stall.
- Branch with FLUSH_CYCLES=3: taken pulse -> if_id_flush=1 for 3 consecutive cycles; state 00→01→01→00; flush_count_o=1. A concurrent load_use during those cycles -> no stall.
- Busy during flush (FLUSH_CYCLES=3): branch, then ex_busy_i high for 4 cycles at flush cycle 2 -> 4 cycles of stall with flush=0, then the remaining 1 flush cycle; stall_cycles_o=4.
- Branch and load_use in the same cycle -> flush+bubble only, pc_stall=0. Busy and branch in the same cycle -> busy wins, flush_count_o unchanged.
- Forwarding: ex_rs1=x7, mem_rd=x7 and wb_rd=x7 both writing -> fwd_a=01; clear mem_reg_write -> 10; all addresses x0 -> 00.
- Reset: assert rst_n=0 mid-FLUSH with counters nonzero -> outputs, state, and counters 0 immediately, with no clock edge needed.
